// File: rtl/tlul_host_arbiter.sv
// Round-robin arbiter sharing one TL-UL device port between NumHosts hosts.
// It allows one outstanding transaction at a time and routes each response back to the issuing host.
package tlul_pkg;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

module tlul_host_arbiter #(
    parameter int NumHosts = 3,
    parameter int HostIdW  = $clog2(NumHosts)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  tlul_pkg::tl_h2d_t    tl_h_i [NumHosts],
    output tlul_pkg::tl_d2h_t    tl_h_o [NumHosts],
    output tlul_pkg::tl_h2d_t    tl_d_o,
    input  tlul_pkg::tl_d2h_t    tl_d_i,
    output logic [HostIdW-1:0]   owner_o,
    output logic                 busy_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        WAIT_RSP = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [HostIdW-1:0]   rr_q, rr_d;
    logic [HostIdW-1:0]   owner_q, owner_d;
    logic                 req_found;
    logic [HostIdW-1:0]   req_pick;

    // First requester at or after rr_q, wrapping by explicit compare so non-power-of-two counts work.
    always_comb begin
        req_found = 1'b0;
        req_pick  = '0;
        for (int i = 0; i < NumHosts; i++) begin
            int                 idx;
            logic [HostIdW-1:0] cand;
            idx = int'(rr_q) + i;
            if (idx >= NumHosts) begin
                idx = idx - NumHosts;
            end
            cand = HostIdW'(idx);
            if (!req_found && tl_h_i[cand].a_valid) begin
                req_found = 1'b1;
                req_pick  = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        tl_d_o         = '0;
        tl_d_o.d_ready = 1'b1;
        for (int k = 0; k < NumHosts; k++) begin
            tl_h_o[k] = '0;
        end

        case (state_q)
            IDLE: begin
                // d_ready stays high here so stale responses are drained and dropped.
                if (req_found) begin
                    owner_d = req_pick;
                    state_d = GRANT;
                end
            end

            GRANT: begin
                tl_d_o                   = tl_h_i[owner_q];
                tl_d_o.d_ready           = 1'b1;
                tl_h_o[owner_q].a_ready  = tl_d_i.a_ready;
                if (!tl_h_i[owner_q].a_valid) begin
                    state_d = IDLE;
                end else if (tl_d_i.a_ready) begin
                    state_d = WAIT_RSP;
                end
            end

            WAIT_RSP: begin
                tl_d_o.d_ready          = tl_h_i[owner_q].d_ready;
                tl_h_o[owner_q]         = tl_d_i;
                tl_h_o[owner_q].a_ready = 1'b0;
                if (tl_d_i.d_valid && tl_h_i[owner_q].d_ready) begin
                    rr_d    = (owner_q == HostIdW'(NumHosts - 1)) ? '0 : owner_q + HostIdW'(1);
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rr_q    <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
        end
    end

    assign owner_o = owner_q;
    assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_tlul_host_arbiter.sv
// Directed bench for tlul_host_arbiter: a scoreboard of expected grants and responses
// is filled by the stimulus and drained by an independent monitor.
module tb_tlul_host_arbiter;

    localparam int NH = 3;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    tlul_pkg::tl_h2d_t h2d [NH];
    tlul_pkg::tl_d2h_t h2o [NH];
    tlul_pkg::tl_h2d_t dreq;
    tlul_pkg::tl_d2h_t drsp;
    logic [1:0]        owner;
    logic              busy;

    logic [NH-1:0] h_valid;
    logic [NH-1:0] h_dready;
    logic [31:0]   h_addr [NH];

    logic          dev_aready;
    logic          dev_dvalid;
    logic [31:0]   dev_data;
    logic [7:0]    dev_src;
    logic          dev_busy;
    int            dev_delay;

    typedef struct {
        int          host;
        logic [31:0] val;
    } exp_t;
    exp_t exp_g[$];
    exp_t exp_r[$];

    int n_chk = 0;
    int n_fail = 0;
    int rsp_cyc = 0;

    tlul_host_arbiter #(.NumHosts(NH)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .tl_h_i  (h2d),
        .tl_h_o  (h2o),
        .tl_d_o  (dreq),
        .tl_d_i  (drsp),
        .owner_o (owner),
        .busy_o  (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int k = 0; k < NH; k++) begin
            h2d[k]           = '0;
            h2d[k].a_valid   = h_valid[k];
            h2d[k].a_opcode  = 3'd4;
            h2d[k].a_size    = 2'd2;
            h2d[k].a_mask    = 4'hF;
            h2d[k].a_source  = 8'(k);
            h2d[k].a_address = h_addr[k];
            h2d[k].d_ready   = h_dready[k];
        end
    end

    always_comb begin
        drsp          = '0;
        drsp.a_ready  = dev_aready;
        drsp.d_valid  = dev_dvalid;
        drsp.d_opcode = 3'd1;
        drsp.d_size   = 2'd2;
        drsp.d_source = dev_src;
        drsp.d_data   = dev_data;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s timed out (t=%0t)", nm, $time);
    endtask

    task automatic push_g(input int h, input logic [31:0] a);
        exp_t e;
        e.host = h;
        e.val  = a;
        exp_g.push_back(e);
    endtask

    task automatic push_r(input int h, input logic [31:0] d);
        exp_t e;
        e.host = h;
        e.val  = d;
        exp_r.push_back(e);
    endtask

    task automatic issue(input int k, input logic [31:0] a);
        h_addr[k]  = a;
        h_valid[k] = 1'b1;
    endtask

    task automatic chk_reset();
        logic [NH-1:0] ar;
        logic [NH-1:0] dv;
        for (int k = 0; k < NH; k++) begin
            ar[k] = h2o[k].a_ready;
            dv[k] = h2o[k].d_valid;
        end
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_dev_avalid", 32'(dreq.a_valid), 32'd0);
        chk("rst_dev_dready", 32'(dreq.d_ready), 32'd1);
        chk("rst_host_aready", 32'(ar), 32'd0);
        chk("rst_host_dvalid", 32'(dv), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        chk_reset();
    endtask

    task automatic wait_drained(input string nm, input int budget);
        bool_wait: begin
            for (int i = 0; i < budget; i++) begin
                @(negedge clk);
                if (exp_g.size() == 0 && exp_r.size() == 0 && !dev_busy && h_valid == '0) begin
                    disable bool_wait;
                end
            end
            fail_timeout(nm);
        end
    endtask

    task automatic wait_dev_avalid(input string nm);
        int i;
        for (i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dreq.a_valid) break;
        end
        if (i == 10) fail_timeout(nm);
    endtask

    // Host side: a request is withdrawn by the host model once it has been accepted.
    initial begin
        logic [NH-1:0] acc;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NH; k++) acc[k] = h_valid[k] & h2o[k].a_ready;
            @(posedge clk); #1;
            h_valid = h_valid & ~acc;
        end
    end

    // Device model: answers each accepted request after dev_delay cycles with address ^ 0xDAFEF009.
    initial begin
        logic [31:0] paddr;
        logic [7:0]  psrc;
        logic        hs;
        dev_dvalid = 1'b0;
        dev_busy   = 1'b0;
        dev_data   = '0;
        dev_src    = '0;
        forever begin
            @(negedge clk);
            if (dreq.a_valid && dev_aready) begin
                dev_busy = 1'b1;
                paddr    = dreq.a_address;
                psrc     = dreq.a_source;
                @(posedge clk); #1;
                repeat (dev_delay) begin
                    @(posedge clk); #1;
                end
                dev_data   = paddr ^ 32'hDAFE_F009;
                dev_src    = psrc;
                dev_dvalid = 1'b1;
                do begin
                    @(negedge clk);
                    hs = dreq.d_ready;
                    @(posedge clk); #1;
                end while (!hs);
                dev_dvalid = 1'b0;
                dev_busy   = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted request and every delivered response.
    initial begin
        exp_t e;
        logic bad;
        forever begin
            @(negedge clk);
            if (!rst) begin
                bad = 1'b0;
                for (int k = 0; k < NH; k++) begin
                    if ((h2o[k].a_ready || h2o[k].d_valid) && !(busy && 32'(owner) == k)) bad = 1'b1;
                end
                chk("nonowner_quiet", 32'(bad), 32'd0);

                if (dreq.a_valid && dev_aready) begin
                    if (exp_g.size() == 0) begin
                        chk("unexpected_grant_owner", 32'(owner), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_g.pop_front();
                        chk("grant_owner", 32'(owner), 32'(e.host));
                        chk("grant_addr", dreq.a_address, e.val);
                        chk("grant_aready", 32'(h2o[e.host].a_ready), 32'd1);
                    end
                end

                for (int k = 0; k < NH; k++) begin
                    if (h2o[k].d_valid && h_dready[k]) begin
                        if (exp_r.size() == 0) begin
                            chk("unexpected_rsp_host", 32'(k), 32'hFFFF_FFFF);
                        end else begin
                            e = exp_r.pop_front();
                            chk("rsp_host", 32'(k), 32'(e.host));
                            chk("rsp_data", h2o[k].d_data, e.val);
                            rsp_cyc = cyc;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog expired (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int i;
        logic [31:0] snap_addr;
        logic [17:0] snap_ctl;
        logic [NH-1:0] dv;

        rst        = 1'b1;
        h_valid    = '0;
        h_dready   = '1;
        for (int k = 0; k < NH; k++) h_addr[k] = '0;
        dev_aready = 1'b1;
        dev_delay  = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset();
        @(posedge clk); #2;
        rst = 1'b0;

        // Single host: Get from host 1.
        push_g(1, 32'h1000_0004);
        push_r(1, 32'hCAFE_F00D);
        @(posedge clk); #2;
        issue(1, 32'h1000_0004);
        t0 = cyc;
        @(negedge clk);
        chk("grant_lat_same", 32'(dreq.a_valid), 32'd0);
        @(negedge clk);
        chk("grant_lat_next", 32'(dreq.a_valid), 32'd1);
        wait_drained("single_host", 20);
        chk("single_cycles", 32'(rsp_cyc - t0), 32'd3);
        chk("single_owner", 32'(owner), 32'd1);

        // All three hosts at once after reset; host 0 re-requests after its grant.
        do_reset();
        push_g(0, 32'h0000_0100); push_r(0, 32'hDAFE_F109);
        push_g(1, 32'h1000_0004); push_r(1, 32'hCAFE_F00D);
        push_g(2, 32'h2000_0000); push_r(2, 32'hFAFE_F009);
        push_g(0, 32'h3000_0010); push_r(0, 32'hEAFE_F019);
        @(posedge clk); #2;
        issue(0, 32'h0000_0100);
        issue(1, 32'h1000_0004);
        issue(2, 32'h2000_0000);
        for (i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!h_valid[0]) break;
        end
        if (i == 10) fail_timeout("rr_first_accept");
        @(posedge clk); #2;
        issue(0, 32'h3000_0010);
        wait_drained("round_robin", 40);

        // Device back-pressure on host 2 (rr now points at 1).
        push_g(2, 32'h4000_0008);
        push_r(2, 32'h9AFE_F001);
        @(posedge clk); #2;
        dev_aready = 1'b0;
        issue(2, 32'h4000_0008);
        wait_dev_avalid("bp_grant");
        snap_addr = dreq.a_address;
        snap_ctl  = {dreq.a_opcode, dreq.a_size, dreq.a_mask, dreq.a_source, 1'b0};
        for (int c = 0; c < 5; c++) begin
            if (c != 0) @(negedge clk);
            chk("bp_addr_stable", dreq.a_address, snap_addr);
            chk("bp_ctl_stable", 32'({dreq.a_opcode, dreq.a_size, dreq.a_mask, dreq.a_source, 1'b0}), 32'(snap_ctl));
            chk("bp_owner_aready", 32'(h2o[2].a_ready), 32'd0);
        end
        @(posedge clk); #2;
        dev_aready = 1'b1;
        wait_drained("backpressure", 20);

        // Host d_ready low while the device holds d_valid.
        push_g(0, 32'h0000_0100);
        push_r(0, 32'hDAFE_F109);
        dev_delay = 0;
        @(posedge clk); #2;
        h_dready[0] = 1'b0;
        issue(0, 32'h0000_0100);
        for (i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dev_dvalid) break;
        end
        if (i == 10) fail_timeout("dr_dvalid");
        for (int c = 0; c < 3; c++) begin
            if (c != 0) @(negedge clk);
            chk("dr_dev_dready", 32'(dreq.d_ready), 32'd0);
            chk("dr_busy", 32'(busy), 32'd1);
            chk("dr_host_dvalid", 32'(h2o[0].d_valid), 32'd1);
        end
        @(posedge clk); #2;
        h_dready[0] = 1'b1;
        @(negedge clk);
        chk("dr_done_now", 32'(exp_r.size()), 32'd0);
        @(negedge clk);
        chk("dr_idle_after", 32'(busy), 32'd0);
        wait_drained("dready_low", 20);

        // Reset while waiting for the response of host 1; the late response must be dropped.
        push_g(1, 32'h1000_0004);
        dev_delay = 3;
        @(posedge clk); #2;
        issue(1, 32'h1000_0004);
        for (i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy && !dreq.a_valid) break;
        end
        if (i == 10) fail_timeout("mr_wait_rsp");
        do_reset();
        for (i = 0; i < 12; i++) begin
            if (i != 0) @(negedge clk);
            if (dev_dvalid) begin
                for (int k = 0; k < NH; k++) dv[k] = h2o[k].d_valid;
                chk("stale_dev_dready", 32'(dreq.d_ready), 32'd1);
                chk("stale_host_dvalid", 32'(dv), 32'd0);
            end
            if (!dev_busy) break;
        end
        if (i == 12) fail_timeout("stale_drain");
        dev_delay = 1;

        // Withdrawal: host 0 drops its request in GRANT; rr must stay at 0.
        @(posedge clk); #2;
        dev_aready = 1'b0;
        issue(0, 32'h0000_0100);
        wait_dev_avalid("wd_grant");
        chk("wd_owner", 32'(owner), 32'd0);
        @(posedge clk); #2;
        h_valid[0] = 1'b0;
        @(negedge clk);
        chk("wd_dev_avalid", 32'(dreq.a_valid), 32'd0);
        @(negedge clk);
        chk("wd_idle", 32'(busy), 32'd0);
        push_g(0, 32'h3000_0010); push_r(0, 32'hEAFE_F019);
        push_g(2, 32'h2000_0000); push_r(2, 32'hFAFE_F009);
        @(posedge clk); #2;
        dev_aready = 1'b1;
        issue(2, 32'h2000_0000);
        issue(0, 32'h3000_0010);
        wait_drained("withdrawal", 30);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
